bus_sequencer: RTL and testbench
================================

Name: bus_sequencer

Overview:
Moore control FSM that sequences the 32-bit single-bus datapath: fetch, decode and multi-step execute. It drives the bus source select lines (r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, in_port_out, c_out) consumed by the bus encoder, plus all register load enables, ALU op and memory handshake. One source on the bus per cycle, guaranteed by construction.

Parameters:
OPC_W, 5, opcode width taken from ir[31:27]
MEM_TIMEOUT, 15, max cycles waiting mem_done before fault

Ports:
clk  in  1  system clock, rising edge
clr  in  1  synchronous active-high reset
run  in  1  1 = leave IDLE and start fetching
ir_opcode  in  5  ir[31:27] from IR
mem_done  in  1  memory completes current read/write
r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, in_port_out, c_out  out  1 each  bus source selects
gra, grb, grc  out  1 each  register-field select to select/encode logic
r_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in  out  1 each  load enables
mdr_read  out  1  MDR mux: 1 = memory data, 0 = bus
inc_pc  out  1  ALU forms PC+1
alu_op  out  5  ALU function (package codes)
mem_read, mem_write  out  1 each  memory request, held until mem_done
halted  out  1  HALT executed
fault  out  1  memory timeout, sticky

Behaviour:
- clr high at a clk edge: state <= IDLE, wait counter <= 0, halted/fault <= 0; every output 0 in IDLE.
- Outputs decode only from the state register; no input-to-output paths.
- IDLE -> F0 when run=1, else stay.
- F0: pc_out, mar_in, inc_pc, z_in. -> F1.
- F1: z_low_out, pc_in, mem_read, mdr_read, mdr_in. Stay while mem_done=0; -> F2 on mem_done=1 (MDR captures that cycle).
- F2: mdr_out, ir_in. -> DEC.
- DEC: no outputs; branch on ir_opcode. Unknown opcode -> F0 (nop).
- R-type ALU (add, sub, and, or, shr, shl): E3 grb,r_out,y_in; E4 grc,r_out,alu_op,z_in; E5 z_low_out,gra,r_in -> F0.
- Immediate (addi, andi, ori): as R-type but E4 uses c_out instead of grc,r_out.
- mul/div: E3 gra,r_out,y_in; E4 grb,r_out,alu_op,z_in; E5 z_low_out,lo_in; E6 z_high_out,hi_in -> F0.
- ld: E3 grb,r_out,y_in; E4 c_out,alu_op=ADD,z_in; E5 z_low_out,mar_in; E6 mem_read,mdr_read,mdr_in (wait for mem_done); E7 mdr_out,gra,r_in -> F0.
- st: E3-E5 as ld; E6 gra,r_out,mdr_in (mdr_read=0); E7 mem_write (wait for mem_done) -> F0.
- mfhi / mflo / in: single E3 with hi_out / lo_out / in_port_out plus gra,r_in -> F0.
- halt: -> HALT; halted=1, all else 0; only clr exits.
- Wait states: counter cleared on entry, +1 per cycle without mem_done; reaching MEM_TIMEOUT -> FAULT (fault=1, all else 0, exit only by clr). mem_done on the timeout cycle wins.
- mem_done outside a wait state ignored.
- alu_op = 0 except in the ALU step.
- Invariant: at most one *_out bus source high every cycle; mem_read and mem_write never together.
- run only sampled in IDLE; run=0 mid-instruction has no effect.
- clr mid-instruction or mid-wait: IDLE next cycle, request dropped.

Decomposition:
- Package cpu_ctrl_pkg: opcode constants (LD=0, LDI=1, ST=2, ADD=3, SUB=4, AND=5, OR=6, SHR=7, SHL=8, ADDI=9, ANDI=10, ORI=11, MUL=12, DIV=13, MFHI=14, MFLO=15, IN=16, HALT=31), ALU op codes, state enum.
- No sub-module needed; the wait counter stays inline.

Test Plan:
- clr=1 two cycles, run=1 -> all outputs 0; after clr drops, F0 next cycle: pc_out=mar_in=inc_pc=z_in=1.
- add, mem_done 3 cycles after mem_read -> F1 lasts 3 cycles; pulses F2,DEC,E3,E4(alu_op=ADD),E5(r_in); 9 cycles total; back in F0.
- mul -> E5 z_low_out+lo_in, E6 z_high_out+hi_in; exactly one bus source per cycle (assertion all tests).
- st, mem_done held low -> mem_write high 15 cycles, then fault=1, state FAULT; only clr clears it.
- ld with clr asserted during E6 wait -> next cycle IDLE, mem_read=0, all outputs 0.
- opcode 20 (undefined) -> DEC then F0, no r_in/hi_in/lo_in; halt -> halted=1 held until clr.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the single-bus CPU control path: opcodes, ALU functions,
// sequencer state codes and the opcode-to-ALU-function map.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'd0;
    localparam logic [4:0] OP_LDI  = 5'd1;
    localparam logic [4:0] OP_ST   = 5'd2;
    localparam logic [4:0] OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_SHR  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_ADDI = 5'd9;
    localparam logic [4:0] OP_ANDI = 5'd10;
    localparam logic [4:0] OP_ORI  = 5'd11;
    localparam logic [4:0] OP_MUL  = 5'd12;
    localparam logic [4:0] OP_DIV  = 5'd13;
    localparam logic [4:0] OP_MFHI = 5'd14;
    localparam logic [4:0] OP_MFLO = 5'd15;
    localparam logic [4:0] OP_IN   = 5'd16;
    localparam logic [4:0] OP_HALT = 5'd31;

    localparam logic [4:0] ALU_NOP = 5'd0;
    localparam logic [4:0] ALU_ADD = 5'd1;
    localparam logic [4:0] ALU_SUB = 5'd2;
    localparam logic [4:0] ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4;
    localparam logic [4:0] ALU_SHR = 5'd5;
    localparam logic [4:0] ALU_SHL = 5'd6;
    localparam logic [4:0] ALU_MUL = 5'd7;
    localparam logic [4:0] ALU_DIV = 5'd8;

    // R_*: register ALU, I_*: immediate ALU, M_*: mul/div, A_*: ld/st address phase
    localparam logic [4:0] S_IDLE  = 5'd0;
    localparam logic [4:0] S_F0    = 5'd1;
    localparam logic [4:0] S_F1    = 5'd2;
    localparam logic [4:0] S_F2    = 5'd3;
    localparam logic [4:0] S_DEC   = 5'd4;
    localparam logic [4:0] S_R3    = 5'd5;
    localparam logic [4:0] S_R4    = 5'd6;
    localparam logic [4:0] S_I3    = 5'd7;
    localparam logic [4:0] S_I4    = 5'd8;
    localparam logic [4:0] S_WB5   = 5'd9;
    localparam logic [4:0] S_M3    = 5'd10;
    localparam logic [4:0] S_M4    = 5'd11;
    localparam logic [4:0] S_M5    = 5'd12;
    localparam logic [4:0] S_M6    = 5'd13;
    localparam logic [4:0] S_A3    = 5'd14;
    localparam logic [4:0] S_A4    = 5'd15;
    localparam logic [4:0] S_A5    = 5'd16;
    localparam logic [4:0] S_LD6   = 5'd17;
    localparam logic [4:0] S_LD7   = 5'd18;
    localparam logic [4:0] S_ST6   = 5'd19;
    localparam logic [4:0] S_ST7   = 5'd20;
    localparam logic [4:0] S_MFHI  = 5'd21;
    localparam logic [4:0] S_MFLO  = 5'd22;
    localparam logic [4:0] S_IN    = 5'd23;
    localparam logic [4:0] S_HALT  = 5'd24;
    localparam logic [4:0] S_FAULT = 5'd25;

    function automatic logic [4:0] alu_for(input logic [4:0] opc);
        case (opc)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI: alu_for = ALU_ADD;
            OP_SUB:                                alu_for = ALU_SUB;
            OP_AND, OP_ANDI:                       alu_for = ALU_AND;
            OP_OR, OP_ORI:                         alu_for = ALU_OR;
            OP_SHR:                                alu_for = ALU_SHR;
            OP_SHL:                                alu_for = ALU_SHL;
            OP_MUL:                                alu_for = ALU_MUL;
            OP_DIV:                                alu_for = ALU_DIV;
            default:                               alu_for = ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/bus_sequencer.sv
// Moore control FSM for the single-bus datapath: fetch, decode, multi-step execute.
// Every output decodes from registered state only, so each state drives at most one bus source.
module bus_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             mem_done,
    output logic r_out, output logic hi_out, output logic lo_out,
    output logic z_high_out, output logic z_low_out, output logic pc_out,
    output logic mdr_out, output logic in_port_out, output logic c_out,
    output logic gra, output logic grb, output logic grc,
    output logic r_in, output logic hi_in, output logic lo_in, output logic pc_in,
    output logic ir_in, output logic mar_in, output logic mdr_in, output logic y_in,
    output logic z_in,
    output logic       mdr_read,
    output logic       inc_pc,
    output logic [4:0] alu_op,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [4:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       alu_q, alu_d;
    logic             is_st_q, is_st_d;
    logic [4:0]       opc;
    logic             wait_st;

    assign opc     = 5'(ir_opcode);
    assign wait_st = (state_q == S_F1) || (state_q == S_LD6) || (state_q == S_ST7);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        alu_d   = alu_q;
        is_st_d = is_st_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_F0;
            S_F0:   state_d = S_F1;
            S_F1:   if (mem_done) state_d = S_F2;
            S_F2:   state_d = S_DEC;
            S_DEC: begin
                alu_d   = alu_for(opc);
                is_st_d = (opc == OP_ST);
                case (opc)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: state_d = S_R3;
                    OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:              state_d = S_I3;
                    OP_MUL, OP_DIV:                                state_d = S_M3;
                    OP_LD, OP_ST:                                  state_d = S_A3;
                    OP_MFHI:                                       state_d = S_MFHI;
                    OP_MFLO:                                       state_d = S_MFLO;
                    OP_IN:                                         state_d = S_IN;
                    OP_HALT:                                       state_d = S_HALT;
                    default:                                       state_d = S_F0;
                endcase
            end
            S_R3:   state_d = S_R4;
            S_R4:   state_d = S_WB5;
            S_I3:   state_d = S_I4;
            S_I4:   state_d = S_WB5;
            S_M3:   state_d = S_M4;
            S_M4:   state_d = S_M5;
            S_M5:   state_d = S_M6;
            S_A3:   state_d = S_A4;
            S_A4:   state_d = S_A5;
            S_A5:   state_d = is_st_q ? S_ST6 : S_LD6;
            S_LD6:  if (mem_done) state_d = S_LD7;
            S_ST6:  state_d = S_ST7;
            S_ST7:  if (mem_done) state_d = S_F0;
            S_HALT, S_FAULT: state_d = state_q;
            default: state_d = S_F0;
        endcase
        // mem_done on the last allowed cycle completes the access rather than faulting
        if (wait_st && !mem_done) begin
            if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) state_d = S_FAULT;
            else                                   cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            alu_q   <= ALU_NOP;
            is_st_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            alu_q   <= alu_d;
            is_st_q <= is_st_d;
        end
    end

    always_comb begin
        {r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, in_port_out, c_out} = '0;
        {gra, grb, grc} = '0;
        {r_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in} = '0;
        {mdr_read, inc_pc, mem_read, mem_write, halted, fault} = '0;
        alu_op = ALU_NOP;
        case (state_q)
            S_F0:    begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
            S_F1:    begin z_low_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_read = 1'b1; mdr_in = 1'b1; end
            S_F2:    begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_R3, S_I3, S_A3: begin grb = 1'b1; r_out = 1'b1; y_in = 1'b1; end
            S_R4:    begin grc = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_q; end
            S_I4, S_A4: begin c_out = 1'b1; z_in = 1'b1; alu_op = alu_q; end
            S_WB5:   begin z_low_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_M3:    begin gra = 1'b1; r_out = 1'b1; y_in = 1'b1; end
            S_M4:    begin grb = 1'b1; r_out = 1'b1; z_in = 1'b1; alu_op = alu_q; end
            S_M5:    begin z_low_out = 1'b1; lo_in = 1'b1; end
            S_M6:    begin z_high_out = 1'b1; hi_in = 1'b1; end
            S_A5:    begin z_low_out = 1'b1; mar_in = 1'b1; end
            S_LD6:   begin mem_read = 1'b1; mdr_read = 1'b1; mdr_in = 1'b1; end
            S_LD7:   begin mdr_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_ST6:   begin gra = 1'b1; r_out = 1'b1; mdr_in = 1'b1; end
            S_ST7:   mem_write = 1'b1;
            S_MFHI:  begin hi_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_MFLO:  begin lo_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_IN:    begin in_port_out = 1'b1; gra = 1'b1; r_in = 1'b1; end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: per-cycle expected control words for each instruction class.
module tb_bus_sequencer;

    logic       clk = 1'b0;
    logic       clr, run, mem_done;
    logic [4:0] ir_opcode;
    logic r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, in_port_out, c_out;
    logic gra, grb, grc;
    logic r_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in;
    logic mdr_read, inc_pc, mem_read, mem_write, halted, fault;
    logic [4:0] alu_op;

    bus_sequencer #(.OPC_W(5), .MEM_TIMEOUT(15)) dut (
        .clk(clk), .clr(clr), .run(run), .ir_opcode(ir_opcode), .mem_done(mem_done),
        .r_out(r_out), .hi_out(hi_out), .lo_out(lo_out), .z_high_out(z_high_out),
        .z_low_out(z_low_out), .pc_out(pc_out), .mdr_out(mdr_out), .in_port_out(in_port_out),
        .c_out(c_out), .gra(gra), .grb(grb), .grc(grc),
        .r_in(r_in), .hi_in(hi_in), .lo_in(lo_in), .pc_in(pc_in), .ir_in(ir_in),
        .mar_in(mar_in), .mdr_in(mdr_in), .y_in(y_in), .z_in(z_in),
        .mdr_read(mdr_read), .inc_pc(inc_pc), .alu_op(alu_op),
        .mem_read(mem_read), .mem_write(mem_write), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    logic [26:0] outs;
    assign outs = {r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out, in_port_out, c_out,
                   gra, grb, grc, r_in, hi_in, lo_in, pc_in, ir_in, mar_in, mdr_in, y_in, z_in,
                   mdr_read, inc_pc, mem_read, mem_write, halted, fault};

    localparam logic [26:0] R_OUT = 27'd1 << 26, HI_OUT = 27'd1 << 25, LO_OUT = 27'd1 << 24;
    localparam logic [26:0] ZH_OUT = 27'd1 << 23, ZL_OUT = 27'd1 << 22, PC_OUT = 27'd1 << 21;
    localparam logic [26:0] MDR_OUT = 27'd1 << 20, INP_OUT = 27'd1 << 19, C_OUT = 27'd1 << 18;
    localparam logic [26:0] GRA = 27'd1 << 17, GRB = 27'd1 << 16, GRC = 27'd1 << 15;
    localparam logic [26:0] R_IN = 27'd1 << 14, HI_IN = 27'd1 << 13, LO_IN = 27'd1 << 12;
    localparam logic [26:0] PC_IN = 27'd1 << 11, IR_IN = 27'd1 << 10, MAR_IN = 27'd1 << 9;
    localparam logic [26:0] MDR_IN = 27'd1 << 8, Y_IN = 27'd1 << 7, Z_IN = 27'd1 << 6;
    localparam logic [26:0] MDR_RD = 27'd1 << 5, INC_PC = 27'd1 << 4, MEM_RD = 27'd1 << 3;
    localparam logic [26:0] MEM_WR = 27'd1 << 2, HALTED = 27'd1 << 1, FAULT = 27'd1;

    localparam logic [26:0] W_F0  = PC_OUT | MAR_IN | INC_PC | Z_IN;
    localparam logic [26:0] W_F1  = ZL_OUT | PC_IN | MEM_RD | MDR_RD | MDR_IN;
    localparam logic [26:0] W_F2  = MDR_OUT | IR_IN;
    localparam logic [26:0] W_B3  = GRB | R_OUT | Y_IN;
    localparam logic [26:0] W_WB  = ZL_OUT | GRA | R_IN;
    localparam logic [26:0] W_IMM = C_OUT | Z_IN;

    localparam logic [4:0] A_ADD = 5'd1, A_MUL = 5'd7;

    int checks = 0;
    int fails  = 0;

    logic [26:0] ex_q[$];
    logic [4:0]  ao_q[$];
    logic        md_q[$];

    task automatic clear_steps();
        ex_q.delete(); ao_q.delete(); md_q.delete();
    endtask

    // one expected cycle: control word, alu_op, and mem_done to drive for the following edge
    task automatic add_step(input logic [26:0] e, input logic [4:0] a, input logic m);
        ex_q.push_back(e); ao_q.push_back(a); md_q.push_back(m);
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            checks++;
            if (($countones({r_out, hi_out, lo_out, z_high_out, z_low_out, pc_out, mdr_out,
                             in_port_out, c_out}) > 1) || (mem_read && mem_write)) begin
                fails++;
                $display("FAIL bus_exclusive t=%0t: outs=%h, want at most one source and no rd+wr", $time, outs);
            end
        end
    end

    task automatic test_reset();
        clr = 1'b1; run = 1'b1; mem_done = 1'b0; ir_opcode = 5'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (outs !== 27'd0 || alu_op !== 5'd0) begin
                fails++;
                $display("FAIL reset cyc%0d: outs=%h alu=%0d, want 0", i, outs, alu_op);
            end
        end
        clr = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== W_F0) begin
            fails++;
            $display("FAIL reset_to_f0: outs=%h, want %h", outs, W_F0);
        end
        run = 1'b0;
    endtask

    task automatic test_add();
        clear_steps();
        ir_opcode = 5'd3;
        add_step(W_F1, 0, 0); add_step(W_F1, 0, 0); add_step(W_F1, 0, 1);
        add_step(W_F2, 0, 0); add_step(0, 0, 0); add_step(W_B3, 0, 0);
        add_step(GRC | R_OUT | Z_IN, A_ADD, 0); add_step(W_WB, 0, 0); add_step(W_F0, 0, 0);
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL add step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
        end
    endtask

    task automatic test_mul();
        clear_steps();
        ir_opcode = 5'd12;
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(GRA | R_OUT | Y_IN, 0, 0); add_step(GRB | R_OUT | Z_IN, A_MUL, 0);
        add_step(ZL_OUT | LO_IN, 0, 0); add_step(ZH_OUT | HI_IN, 0, 0); add_step(W_F0, 0, 0);
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL mul step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
        end
    endtask

    // addi with a fetch that completes on the very last cycle before timeout, then mfhi and in
    task automatic test_imm_move();
        clear_steps();
        for (int k = 0; k < 14; k++) add_step(W_F1, 0, 0);
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(W_B3, 0, 0); add_step(W_IMM, A_ADD, 0); add_step(W_WB, 0, 0); add_step(W_F0, 0, 0);
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(HI_OUT | GRA | R_IN, 0, 0); add_step(W_F0, 0, 0);
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(INP_OUT | GRA | R_IN, 0, 0); add_step(W_F0, 0, 0);
        ir_opcode = 5'd9;
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL imm_move step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
            if (i == 20) ir_opcode = 5'd14;
            if (i == 25) ir_opcode = 5'd16;
        end
    endtask

    task automatic test_ld();
        clear_steps();
        ir_opcode = 5'd0;
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(W_B3, 0, 0); add_step(W_IMM, A_ADD, 0); add_step(ZL_OUT | MAR_IN, 0, 0);
        add_step(MEM_RD | MDR_RD | MDR_IN, 0, 0); add_step(MEM_RD | MDR_RD | MDR_IN, 0, 1);
        add_step(MDR_OUT | GRA | R_IN, 0, 0); add_step(W_F0, 0, 0);
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL ld step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
        end
    endtask

    task automatic test_ld_clr();
        clear_steps();
        ir_opcode = 5'd0;
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(W_B3, 0, 0); add_step(W_IMM, A_ADD, 0); add_step(ZL_OUT | MAR_IN, 0, 0);
        add_step(MEM_RD | MDR_RD | MDR_IN, 0, 0); add_step(MEM_RD | MDR_RD | MDR_IN, 0, 0);
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL ld_clr step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
        end
        clr = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== 27'd0 || mem_read !== 1'b0) begin
            fails++;
            $display("FAIL ld_clr_idle: outs=%h mem_read=%b, want 0", outs, mem_read);
        end
        clr = 1'b0; run = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 27'd0) begin
            fails++;
            $display("FAIL idle_hold: outs=%h, want 0", outs);
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== W_F0) begin
            fails++;
            $display("FAIL idle_run: outs=%h, want %h", outs, W_F0);
        end
        run = 1'b0;
    endtask

    task automatic test_st_timeout();
        clear_steps();
        ir_opcode = 5'd2;
        run = 1'b1;
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(W_B3, 0, 0); add_step(W_IMM, A_ADD, 0); add_step(ZL_OUT | MAR_IN, 0, 0);
        add_step(GRA | R_OUT | MDR_IN, 0, 0);
        for (int k = 0; k < 15; k++) add_step(MEM_WR, 0, 0);
        add_step(FAULT, 0, 1); add_step(FAULT, 0, 1); add_step(FAULT, 0, 0);
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL st_timeout step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
        end
        clr = 1'b1; run = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 27'd0) begin
            fails++;
            $display("FAIL fault_clr: outs=%h, want 0", outs);
        end
        clr = 1'b0; run = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== W_F0) begin
            fails++;
            $display("FAIL fault_restart: outs=%h, want %h", outs, W_F0);
        end
        run = 1'b0;
    endtask

    task automatic test_undef_halt();
        clear_steps();
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0); add_step(W_F0, 0, 0);
        add_step(W_F1, 0, 1); add_step(W_F2, 0, 0); add_step(0, 0, 0);
        add_step(HALTED, 0, 1); add_step(HALTED, 0, 0); add_step(HALTED, 0, 0);
        ir_opcode = 5'd20;
        for (int i = 0; i < ex_q.size(); i++) begin
            @(negedge clk);
            checks++;
            if (outs !== ex_q[i] || alu_op !== ao_q[i]) begin
                fails++;
                $display("FAIL undef_halt step%0d: outs=%h alu=%0d, want %h alu=%0d", i, outs, alu_op, ex_q[i], ao_q[i]);
            end
            mem_done = md_q[i];
            if (i == 3) ir_opcode = 5'd31;
            if (i == 7) run = 1'b1;
        end
        clr = 1'b1; run = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 27'd0) begin
            fails++;
            $display("FAIL halt_clr: outs=%h, want 0", outs);
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_imm_move();
        test_ld();
        test_ld_clr();
        test_st_timeout();
        test_undef_halt();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
